timer_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 16 +
 rtl/btn_edge.sv | 21 ++
 rtl/timer_ctrl.sv | 103 ++++++++++
 tb/tb_timer_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer and its front-panel controller.
package timer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SET   = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4,
        CLR   = 3'd5
    } ctrl_state_t;

    localparam int ADD_STEP = 30;
    localparam int COUNT_W  = 12;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one synchronized button level; a held button yields one rise.
module btn_edge (
    input  logic clk,
    input  logic nrst,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// Front-panel sequencer: button edges, per-second tick prescaler and SET/RUN/PAUSE/DONE mode FSM.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter  int TICK_DIV = 10_000_000,
    localparam int PRE_W    = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       start_btn,
    input  logic       add_btn,
    input  logic       clear_btn,
    input  logic       time_up,
    output logic       enable_dec,
    output logic       enable_in,
    output logic       clk_div,
    output logic       lap,
    output logic       clear,
    output logic       alarm,
    output logic [2:0] mode
);

    logic start_rise;
    logic add_rise;
    logic clear_rise;

    btn_edge u_start_edge (.clk(clk), .nrst(nrst), .level(start_btn), .rise(start_rise));
    btn_edge u_add_edge   (.clk(clk), .nrst(nrst), .level(add_btn),   .rise(add_rise));
    btn_edge u_clear_edge (.clk(clk), .nrst(nrst), .level(clear_btn), .rise(clear_rise));

    // Priority clear > start > add; losers in the same cycle are discarded.
    logic clr_ev;
    logic start_ev;
    logic add_ev;

    assign clr_ev   = clear_rise;
    assign start_ev = start_rise & ~clear_rise;
    assign add_ev   = add_rise & ~start_rise & ~clear_rise;

    ctrl_state_t      state;
    ctrl_state_t      next_state;
    logic [PRE_W-1:0] pre;
    logic             tick_now;

    assign tick_now = (state == RUN) && (pre == PRE_W'(TICK_DIV - 1));

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (clr_ev)      next_state = CLR;
                else if (add_ev) next_state = SET;
            end
            SET: begin
                if (clr_ev)        next_state = CLR;
                else if (start_ev) next_state = RUN;
            end
            RUN: begin
                if (clr_ev)        next_state = CLR;
                else if (time_up)  next_state = DONE;
                else if (start_ev) next_state = PAUSE;
            end
            PAUSE: begin
                if (clr_ev)        next_state = CLR;
                else if (start_ev) next_state = RUN;
                else if (add_ev)   next_state = SET;
            end
            DONE: begin
                if (clr_ev || start_ev) next_state = CLR;
            end
            CLR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The prescaler only advances while RUN continues, so the cycle that leaves RUN
    // does not count toward the partial second kept across a pause.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            pre     <= '0;
            lap     <= 1'b0;
            clear   <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            state   <= next_state;
            lap     <= add_ev && (next_state == SET);
            clear   <= (next_state == CLR);
            clk_div <= tick_now && (next_state == RUN);
            if (state == CLR || (state == SET && next_state == RUN)) begin
                pre <= '0;
            end else if (state == RUN && next_state == RUN) begin
                pre <= tick_now ? '0 : pre + 1'b1;
            end
        end
    end

    assign enable_dec = (state == RUN);
    assign enable_in  = (state == SET);
    assign alarm      = (state == DONE);
    assign mode       = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with TICK_DIV=4; pulse outputs are scoreboarded by cycle.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start_btn;
    logic       add_btn;
    logic       clear_btn;
    logic       time_up;
    logic       enable_dec;
    logic       enable_in;
    logic       clk_div;
    logic       lap;
    logic       clear;
    logic       alarm;
    logic [2:0] mode;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int exp_lap[$];
    int exp_tick[$];
    int exp_clear[$];

    timer_ctrl #(.TICK_DIV(4)) dut (
        .clk(clk), .nrst(nrst),
        .start_btn(start_btn), .add_btn(add_btn), .clear_btn(clear_btn),
        .time_up(time_up),
        .enable_dec(enable_dec), .enable_in(enable_in), .clk_div(clk_div),
        .lap(lap), .clear(clear), .alarm(alarm), .mode(mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: every observed pulse must match the next expected cycle.
    always @(negedge clk) begin
        int e;
        if (lap === 1'b1) begin
            checks++;
            if (mode !== 3'd1) begin
                errors++;
                $display("FAIL lap_mode: got mode %0d during lap, expected 1", mode);
            end
            checks++;
            if (exp_lap.size() == 0) begin
                errors++;
                $display("FAIL lap_unexpected: got lap at cycle %0d, expected none", cyc);
            end else begin
                e = exp_lap.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL lap_cycle: got cycle %0d, expected %0d", cyc, e);
                end
            end
        end
        if (clk_div === 1'b1) begin
            checks++;
            if (mode !== 3'd2) begin
                errors++;
                $display("FAIL tick_mode: got mode %0d during clk_div, expected 2", mode);
            end
            checks++;
            if (exp_tick.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: got clk_div at cycle %0d, expected none", cyc);
            end else begin
                e = exp_tick.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL tick_cycle: got cycle %0d, expected %0d", cyc, e);
                end
            end
        end
        if (clear === 1'b1) begin
            checks++;
            if (exp_clear.size() == 0) begin
                errors++;
                $display("FAIL clear_unexpected: got clear at cycle %0d, expected none", cyc);
            end else begin
                e = exp_clear.pop_front();
                if (e != cyc) begin
                    errors++;
                    $display("FAIL clear_cycle: got cycle %0d, expected %0d", cyc, e);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        nrst      = 1'b0;
        start_btn = 1'b0;
        add_btn   = 1'b0;
        clear_btn = 1'b0;
        time_up   = 1'b0;
        wait_cyc(2);
        checks++;
        if ({enable_dec, enable_in, clk_div, lap, clear, alarm, mode} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {enable_dec, enable_in, clk_div, lap, clear, alarm, mode});
        end
        nrst = 1'b1;
        wait_cyc(20);
        checks++;
        if ({enable_dec, enable_in, clk_div, lap, clear, alarm, mode} !== 9'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %b, expected all zero",
                     {enable_dec, enable_in, clk_div, lap, clear, alarm, mode});
        end
    endtask

    task automatic test_set_lap();
        exp_lap.push_back(cyc + 1);
        add_btn = 1'b1;
        wait_cyc(1);
        checks++;
        if (mode !== 3'd1 || enable_in !== 1'b1) begin
            errors++;
            $display("FAIL set_entry: got mode %0d enable_in %b, expected 1 1", mode, enable_in);
        end
        wait_cyc(9);
        add_btn = 1'b0;
        wait_cyc(1);
        exp_lap.push_back(cyc + 1);
        add_btn = 1'b1;
        wait_cyc(1);
        add_btn = 1'b0;
        wait_cyc(2);
        checks++;
        if (mode !== 3'd1) begin
            errors++;
            $display("FAIL set_stay: got mode %0d, expected 1", mode);
        end
    endtask

    task automatic test_run_pause();
        int entry;
        int resume;
        start_btn = 1'b1;
        entry = cyc + 1;
        exp_tick.push_back(entry + 4);
        exp_tick.push_back(entry + 8);
        exp_tick.push_back(entry + 12);
        wait_cyc(1);
        start_btn = 1'b0;
        checks++;
        if (mode !== 3'd2 || enable_dec !== 1'b1 || enable_in !== 1'b0) begin
            errors++;
            $display("FAIL run_entry: got mode %0d dec %b in %b, expected 2 1 0",
                     mode, enable_dec, enable_in);
        end
        wait_cyc(entry + 12 - cyc);
        wait_cyc(2);
        start_btn = 1'b1;
        wait_cyc(1);
        start_btn = 1'b0;
        checks++;
        if (mode !== 3'd3 || enable_dec !== 1'b0) begin
            errors++;
            $display("FAIL pause_entry: got mode %0d dec %b, expected 3 0", mode, enable_dec);
        end
        wait_cyc(10);
        start_btn = 1'b1;
        resume = cyc + 1;
        exp_tick.push_back(resume + 2);
        exp_tick.push_back(resume + 6);
        wait_cyc(1);
        start_btn = 1'b0;
        checks++;
        if (mode !== 3'd2) begin
            errors++;
            $display("FAIL resume_mode: got mode %0d, expected 2", mode);
        end
        wait_cyc(resume + 6 - cyc);
    endtask

    task automatic test_done_clear();
        wait_cyc(1);
        start_btn = 1'b1;
        time_up   = 1'b1;
        wait_cyc(1);
        start_btn = 1'b0;
        time_up   = 1'b0;
        checks++;
        if (mode !== 3'd4 || alarm !== 1'b1 || enable_dec !== 1'b0) begin
            errors++;
            $display("FAIL done_entry: got mode %0d alarm %b dec %b, expected 4 1 0",
                     mode, alarm, enable_dec);
        end
        wait_cyc(3);
        add_btn = 1'b1;
        wait_cyc(1);
        add_btn = 1'b0;
        checks++;
        if (mode !== 3'd4) begin
            errors++;
            $display("FAIL done_ignore_add: got mode %0d, expected 4", mode);
        end
        exp_clear.push_back(cyc + 1);
        clear_btn = 1'b1;
        wait_cyc(1);
        clear_btn = 1'b0;
        checks++;
        if (mode !== 3'd5 || clear !== 1'b1 || enable_dec !== 1'b0 || enable_in !== 1'b0) begin
            errors++;
            $display("FAIL clr_state: got mode %0d clear %b dec %b in %b, expected 5 1 0 0",
                     mode, clear, enable_dec, enable_in);
        end
        wait_cyc(1);
        checks++;
        if (mode !== 3'd0 || alarm !== 1'b0 || clear !== 1'b0) begin
            errors++;
            $display("FAIL clr_exit: got mode %0d alarm %b clear %b, expected 0 0 0",
                     mode, alarm, clear);
        end
    endtask

    task automatic test_simultaneous();
        exp_lap.push_back(cyc + 1);
        add_btn = 1'b1;
        wait_cyc(1);
        add_btn = 1'b0;
        wait_cyc(1);
        exp_clear.push_back(cyc + 1);
        add_btn   = 1'b1;
        start_btn = 1'b1;
        clear_btn = 1'b1;
        wait_cyc(1);
        checks++;
        if (mode !== 3'd5 || lap !== 1'b0) begin
            errors++;
            $display("FAIL simul_clr: got mode %0d lap %b, expected 5 0", mode, lap);
        end
        wait_cyc(1);
        add_btn   = 1'b0;
        start_btn = 1'b0;
        clear_btn = 1'b0;
        checks++;
        if (mode !== 3'd0) begin
            errors++;
            $display("FAIL simul_idle: got mode %0d, expected 0", mode);
        end
        wait_cyc(3);
    endtask

    task automatic test_reset_mid_run();
        exp_lap.push_back(cyc + 1);
        add_btn = 1'b1;
        wait_cyc(1);
        add_btn   = 1'b0;
        start_btn = 1'b1;
        wait_cyc(1);
        start_btn = 1'b0;
        checks++;
        if (mode !== 3'd2) begin
            errors++;
            $display("FAIL mid_run_entry: got mode %0d, expected 2", mode);
        end
        wait_cyc(1);
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if ({enable_dec, enable_in, clk_div, lap, clear, alarm, mode} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got %b, expected all zero",
                     {enable_dec, enable_in, clk_div, lap, clear, alarm, mode});
        end
        wait_cyc(2);
        nrst = 1'b1;
        wait_cyc(6);
        checks++;
        if (mode !== 3'd0 || enable_dec !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got mode %0d dec %b, expected 0 0", mode, enable_dec);
        end
    endtask

    task automatic test_drain();
        checks++;
        if (exp_lap.size() != 0) begin
            errors++;
            $display("FAIL lap_missing: got %0d pending, expected 0", exp_lap.size());
        end
        checks++;
        if (exp_tick.size() != 0) begin
            errors++;
            $display("FAIL tick_missing: got %0d pending, expected 0", exp_tick.size());
        end
        checks++;
        if (exp_clear.size() != 0) begin
            errors++;
            $display("FAIL clear_missing: got %0d pending, expected 0", exp_clear.size());
        end
    endtask

    initial begin
        test_reset();
        test_set_lap();
        test_run_pause();
        test_done_clear();
        test_simultaneous();
        test_reset_mid_run();
        test_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
